// File: rtl/reg_wr_arbiter.sv
// Two-requester register-file write arbiter with a one-entry registered output stage.
// Define REG_WR_ARB_RR_EN for round-robin tie-breaking; otherwise requester 0 wins ties.
module reg_wr_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    input  logic [3:0]  req0_addr,
    input  logic [31:0] req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [3:0]  req1_addr,
    input  logic [31:0] req1_data,
    output logic        req1_ready,
    input  logic        wr_stall,
    output logic        wr_en,
    output logic [3:0]  write_addr,
    output logic [31:0] write_data,
    output logic [15:0] pending,
    output logic [15:0] written
);

    logic        wr_q, wr_d;
    logic [3:0]  addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [15:0] written_q, written_d;
    logic        grant0, grant1;

`ifdef REG_WR_ARB_RR_EN
    logic        last_grant_q, last_grant_d;
`endif

    // A lone requester always wins; a tie is settled by the configured policy.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (req0_valid && req1_valid) begin
`ifdef REG_WR_ARB_RR_EN
            grant0 = last_grant_q;
            grant1 = ~last_grant_q;
`else
            grant0 = 1'b1;
`endif
        end else begin
            grant0 = req0_valid;
            grant1 = req1_valid;
        end
    end

    assign req0_ready = rst_n & ~wr_stall & grant0;
    assign req1_ready = rst_n & ~wr_stall & grant1;
    assign wr_en      = wr_q & ~wr_stall;
    assign write_addr = addr_q;
    assign write_data = data_q;
    assign pending    = wr_en ? (16'h0001 << addr_q) : 16'h0000;
    assign written    = written_q;

    // A stall freezes the whole output stage, including its valid flag.
    always_comb begin
        wr_d      = wr_q;
        addr_d    = addr_q;
        data_d    = data_q;
        written_d = written_q;
        if (wr_en) begin
            written_d[addr_q] = 1'b1;
        end
        if (!wr_stall) begin
            wr_d = req0_ready | req1_ready;
            if (req0_ready) begin
                addr_d = req0_addr;
                data_d = req0_data;
            end else if (req1_ready) begin
                addr_d = req1_addr;
                data_d = req1_data;
            end
        end
    end

`ifdef REG_WR_ARB_RR_EN
    always_comb begin
        last_grant_d = last_grant_q;
        if (req0_ready) begin
            last_grant_d = 1'b0;
        end else if (req1_ready) begin
            last_grant_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q      <= 1'b0;
            addr_q    <= 4'h0;
            data_q    <= 32'h0;
            written_q <= 16'h0;
        end else begin
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            written_q <= written_d;
        end
    end

endmodule

// File: tb/tb_reg_wr_arbiter.sv
// Self-checking bench for reg_wr_arbiter: per-cycle model comparison plus directed literal checks.
// Expectations follow REG_WR_ARB_RR_EN when the bench is built with it.
module tb_reg_wr_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic [3:0]  req0_addr, req1_addr;
    logic [31:0] req0_data, req1_data;
    logic        req0_ready, req1_ready;
    logic        wr_stall;
    logic        wr_en;
    logic [3:0]  write_addr;
    logic [31:0] write_data;
    logic [15:0] pending;
    logic [15:0] written;

    int checks = 0;
    int errors = 0;

    reg_wr_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .wr_stall   (wr_stall),
        .wr_en      (wr_en),
        .write_addr (write_addr),
        .write_data (write_data),
        .pending    (pending),
        .written    (written)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model: one outstanding accepted write, the set of written registers, and the last winner.
    bit        mValid;
    bit [3:0]  mAddr;
    bit [31:0] mData;
    bit [15:0] mWritten;
    int        mLast;
    int        modelW;
    bit [31:0] tbRegFile [16];

    function automatic int modelWinner(bit v0, bit v1, int lastG);
        if (!v0 && !v1) return -1;
        if (v0 && !v1) return 0;
        if (v1 && !v0) return 1;
`ifdef REG_WR_ARB_RR_EN
        return (lastG == 0) ? 1 : 0;
`else
        return 0;
`endif
    endfunction

    always_comb modelW = modelWinner(req0_valid, req1_valid, mLast);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mValid   <= 1'b0;
            mAddr    <= 4'h0;
            mData    <= 32'h0;
            mWritten <= 16'h0;
            mLast    <= 1;
        end else if (!wr_stall) begin
            if (mValid) mWritten <= mWritten | (16'h0001 << mAddr);
            if (modelW >= 0) begin
                mValid <= 1'b1;
                mAddr  <= (modelW == 0) ? req0_addr : req1_addr;
                mData  <= (modelW == 0) ? req0_data : req1_data;
                mLast  <= modelW;
            end else begin
                mValid <= 1'b0;
            end
        end
    end

    // Register file as seen through the DUT's write port.
    always @(posedge clk) begin
        if (rst_n && wr_en) tbRegFile[write_addr] <= write_data;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            checkOutput("model.req0_ready", {31'b0, req0_ready}, {31'b0, (!wr_stall && modelW == 0)});
            checkOutput("model.req1_ready", {31'b0, req1_ready}, {31'b0, (!wr_stall && modelW == 1)});
            checkOutput("model.wr_en", {31'b0, wr_en}, {31'b0, (mValid && !wr_stall)});
            checkOutput("model.pending", {16'b0, pending},
                        (mValid && !wr_stall) ? (32'h1 << mAddr) : 32'h0);
            checkOutput("model.written", {16'b0, written}, {16'b0, mWritten});
            if (mValid) begin
                checkOutput("model.write_addr", {28'b0, write_addr}, {28'b0, mAddr});
                checkOutput("model.write_data", write_data, mData);
            end
        end
    end

    task automatic applyStimulus(input bit v0, input bit [3:0] a0, input bit [31:0] d0,
                                 input bit v1, input bit [3:0] a1, input bit [31:0] d1,
                                 input bit stall);
        @(posedge clk);
        #1;
        req0_valid = v0; req0_addr = a0; req0_data = d0;
        req1_valid = v1; req1_addr = a1; req1_data = d1;
        wr_stall   = stall;
        @(negedge clk);
        #1;
    endtask

    task automatic pulseReset();
        @(posedge clk);
        #1;
        req0_valid = 1'b0; req1_valid = 1'b0; wr_stall = 1'b0;
        #1 rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b1; req0_addr = 4'h6; req0_data = 32'h55;
        req1_valid = 1'b0; req1_addr = 4'h0; req1_data = 32'h0;
        wr_stall = 1'b0;
        #3;
        checkOutput("reset.req0_ready", {31'b0, req0_ready}, 32'h0);
        checkOutput("reset.wr_en", {31'b0, wr_en}, 32'h0);
        checkOutput("reset.write_addr", {28'b0, write_addr}, 32'h0);
        checkOutput("reset.write_data", write_data, 32'h0);
        checkOutput("reset.pending", {16'b0, pending}, 32'h0);
        checkOutput("reset.written", {16'b0, written}, 32'h0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        req0_valid = 1'b0;

        // Single write: addr 3, data 4.
        applyStimulus(1, 4'd3, 32'd4, 0, 4'd0, 32'd0, 0);
        checkOutput("basic.req0_ready", {31'b0, req0_ready}, 32'h1);
        applyStimulus(0, 4'd0, 32'd0, 0, 4'd0, 32'd0, 0);
        checkOutput("basic.wr_en", {31'b0, wr_en}, 32'h1);
        checkOutput("basic.write_addr", {28'b0, write_addr}, 32'h3);
        checkOutput("basic.write_data", write_data, 32'h4);
        checkOutput("basic.pending", {16'b0, pending}, 32'h0008);
        checkOutput("basic.written_before", {16'b0, written}, 32'h0000);
        applyStimulus(0, 4'd0, 32'd0, 0, 4'd0, 32'd0, 0);
        checkOutput("basic.written_after", {16'b0, written}, 32'h0008);
        checkOutput("basic.wr_en_idle", {31'b0, wr_en}, 32'h0);

        // Contention on distinct addresses, starting from a fresh reset.
        pulseReset();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 4'd1, 32'hA, 1, 4'd2, 32'hB, 0);
`ifdef REG_WR_ARB_RR_EN
            checkOutput("tie.req0_ready", {31'b0, req0_ready}, (i % 2 == 0) ? 32'h1 : 32'h0);
            checkOutput("tie.req1_ready", {31'b0, req1_ready}, (i % 2 == 1) ? 32'h1 : 32'h0);
`else
            checkOutput("tie.req0_ready", {31'b0, req0_ready}, 32'h1);
            checkOutput("tie.req1_ready", {31'b0, req1_ready}, 32'h0);
`endif
        end
        applyStimulus(0, 4'd0, 32'd0, 0, 4'd0, 32'd0, 0);
        applyStimulus(0, 4'd0, 32'd0, 0, 4'd0, 32'd0, 0);
`ifdef REG_WR_ARB_RR_EN
        checkOutput("tie.written", {16'b0, written}, 32'h0006);
`else
        checkOutput("tie.written", {16'b0, written}, 32'h0002);
`endif

        // Same-address contention: the later grant's data must persist.
        applyStimulus(1, 4'd5, 32'd1, 1, 4'd5, 32'd2, 0);
        checkOutput("same.req0_ready", {31'b0, req0_ready}, 32'h1);
        applyStimulus(0, 4'd0, 32'd0, 1, 4'd5, 32'd2, 0);
        checkOutput("same.req1_ready", {31'b0, req1_ready}, 32'h1);
        checkOutput("same.first_data", write_data, 32'd1);
        applyStimulus(0, 4'd0, 32'd0, 0, 4'd0, 32'd0, 0);
        checkOutput("same.second_data", write_data, 32'd2);
        applyStimulus(0, 4'd0, 32'd0, 0, 4'd0, 32'd0, 0);
        checkOutput("same.reg5", tbRegFile[5], 32'd2);
        checkOutput("same.written5", {31'b0, written[5]}, 32'h1);

        // Stall with a write held in the output stage.
        applyStimulus(1, 4'd7, 32'h77, 0, 4'd0, 32'd0, 0);
        checkOutput("stall.accept", {31'b0, req0_ready}, 32'h1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 4'd8, 32'h88, 1, 4'd9, 32'h99, 1);
            checkOutput("stall.wr_en", {31'b0, wr_en}, 32'h0);
            checkOutput("stall.req0_ready", {31'b0, req0_ready}, 32'h0);
            checkOutput("stall.req1_ready", {31'b0, req1_ready}, 32'h0);
            checkOutput("stall.write_addr", {28'b0, write_addr}, 32'h7);
            checkOutput("stall.written7", {31'b0, written[7]}, 32'h0);
        end
        applyStimulus(0, 4'd0, 32'd0, 0, 4'd0, 32'd0, 0);
        checkOutput("stall.release_wr_en", {31'b0, wr_en}, 32'h1);
        checkOutput("stall.release_addr", {28'b0, write_addr}, 32'h7);
        applyStimulus(0, 4'd0, 32'd0, 0, 4'd0, 32'd0, 0);
        checkOutput("stall.after_wr_en", {31'b0, wr_en}, 32'h0);
        checkOutput("stall.written7_after", {31'b0, written[7]}, 32'h1);

        // Reset arriving while a write sits in the output stage.
        applyStimulus(1, 4'd9, 32'h9, 0, 4'd0, 32'd0, 0);
        checkOutput("rst.accept", {31'b0, req0_ready}, 32'h1);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        checkOutput("rst.wr_en", {31'b0, wr_en}, 32'h0);
        checkOutput("rst.written", {16'b0, written}, 32'h0);
        checkOutput("rst.pending", {16'b0, pending}, 32'h0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        applyStimulus(0, 4'd0, 32'd0, 0, 4'd0, 32'd0, 0);
        checkOutput("rst.wr_en_after", {31'b0, wr_en}, 32'h0);
        applyStimulus(0, 4'd0, 32'd0, 0, 4'd0, 32'd0, 0);
        checkOutput("rst.written_after", {16'b0, written}, 32'h0);
        checkOutput("rst.reg9", tbRegFile[9], 32'h0);

        @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_wr_arbiter.md
REG_WR_ARBITER -- requirements
Module: reg_wr_arbiter

Interface
REQ-001 The block SHALL use one clock and one reset: reset is asynchronous and active-low, named rst_n; clock named clk.
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 req0_valid  input  1  requester 0 (ALU writeback) has a write pending.
REQ-005 req0_addr  input  4  requester 0 destination register.
REQ-006 req0_data  input  32  requester 0 write data.
REQ-007 req0_ready  output  1  requester 0 write accepted this cycle when high with req0_valid.
REQ-008 req1_valid, req1_addr, req1_data, req1_ready: same widths/directions/meaning as REQ-004..007 for requester 1 (load writeback).
REQ-009 wr_stall  input  1  holds the register-file write port; no grants, no writes.
REQ-010 wr_en  output  1  register-file write enable.
REQ-011 write_addr  output  4  register-file write address.
REQ-012 write_data  output  32  register-file write data.
REQ-013 pending  output  16  one-hot of write_addr while wr_en=1, else 0.
REQ-014 written  output  16  bit i set once register i has been written since reset.

Function
REQ-015 Transfer on requester N SHALL occur at a rising edge where reqN_valid=1 and reqN_ready=1.
REQ-016 reqN_ready SHALL be combinational: high iff wr_stall=0, reqN_valid=1 and N wins arbitration; at most one ready high per cycle.
REQ-017 Single valid requester SHALL win unconditionally; both valid resolved per REQ-025.
REQ-018 Accepted address/data SHALL be registered into the output stage at the transfer edge; internal valid flag wr_q set, else cleared (when not stalled).
REQ-019 wr_en SHALL equal wr_q AND NOT wr_stall; write_addr/write_data driven from output stage registers.
REQ-020 Latency: transfer at edge k -> wr_en=1 during cycle k..k+1 -> register file writes at edge k+1.
REQ-021 While wr_stall=1 output stage SHALL hold contents including wr_q; no transfers; written unchanged.
REQ-022 written[write_addr] SHALL set at each edge where wr_en=1; bits never clear except on reset.
REQ-023 Both requesters valid with the same address: only the winner is written that cycle; loser stays valid and is written on a later cycle, so the later grant's data persists.
REQ-024 Requester dropping valid without transfer SHALL be legal; no state change.
REQ-025 Arbitration order per Configuration; round-robin pointer last_grant updates only on a transfer.

Reset
REQ-026 On rst_n=0, immediately and asynchronously: wr_q=0, wr_en=0, write_addr=0, write_data=0, pending=0, written=0, last_grant=1 (requester 0 wins first tie), both ready low.
REQ-027 Reset asserted mid-operation SHALL discard any output-stage write; no register-file write occurs at the next edge.
REQ-028 After rst_n deasserts, first grant possible at the first rising edge.

Configuration
REQ-029 Macro REG_WR_ARB_RR_EN defined: ties SHALL go to the requester not equal to last_grant (round-robin).
REQ-030 Macro REG_WR_ARB_RR_EN undefined: ties SHALL always go to requester 0 (fixed priority); last_grant register absent.

Verification
REQ-031 Reset, then req0 valid addr=3 data=4 one cycle -> req0_ready=1; next cycle wr_en=1, write_addr=3, write_data=4, pending=0x0008; after following edge written=0x0008.
REQ-032 Both valid every cycle, req0 addr=1 data=0xA, req1 addr=2 data=0xB, RR build -> grants alternate 0,1,0,1; fixed build -> req0 every cycle, req1_ready stays 0.
REQ-033 Both valid, same addr=5, req0 data=1, req1 data=2, RR build -> wr_en cycles write 1 then 2; final register 5 value 2; written[5]=1.
REQ-034 Accepted write addr=7 then wr_stall=1 for 3 cycles -> wr_en=0, both ready=0, write_addr held 7, written[7]=0; on release wr_en=1 one cycle, written[7]=1.
REQ-035 Transfer addr=9, assert rst_n=0 before next edge -> wr_en=0 immediately, written=0, no write to register 9.
